// File: rtl/fp16_pack_seq.sv
// fp16_pack_seq
// Iterative binary16 result stage. Takes the unnormalized sign / exponent /
// 15-bit extended mantissa sum from the mantissa adder. It normalizes the sum
// one bit per cycle, then rounds and packs it into an IEEE-754 half word.
//
// Build option: FP16_PACK_RNE_EN
//   defined   -> round to nearest, ties to even, using guard/round/sticky
//   undefined -> truncation (overflow to infinity still applies)
//
// Ports:
//   CLK          clock, rising edge
//   RST_N        asynchronous active-low reset
//   IN_VALID     operand triple valid
//   IN_READY     block can take an operand (IDLE only)
//   IN_SIGN_HALF result sign
//   IN_EXP_HALF  biased exponent of the bit-13 position (0 => 1, 31 => inf)
//   IN_MANT_SUM  {carry, hidden, frac[9:0], guard, round, sticky}
//   OUT_VALID    Q holds a result, held until accepted
//   OUT_READY    downstream accepts Q
//   Q            packed binary16 result
module fp16_pack_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        IN_SIGN_HALF,
  input  logic [4:0]  IN_EXP_HALF,
  input  logic [14:0] IN_MANT_SUM,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] Q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r, state_n;
  logic        sign_r, sign_n;
  logic [5:0]  exp_r, exp_n;
  logic [14:0] mant_r, mant_n;
  logic        inf_r, inf_n;
  logic [15:0] q_r, q_n;
  logic        in_ready_r, out_valid_r;

  // Rounding / packing datapath, only consumed in ROUND
  logic [4:0]  field_s;
  logic [14:0] base_s;
  logic        inc_s;
  logic [15:0] sum_s;
  logic        ovf_s;

  // Pack the normalized mantissa into a half word and apply the rounding increment
  always_comb begin
    field_s = 5'd0;
    base_s  = 15'd0;
    inc_s   = 1'b0;
    sum_s   = 16'd0;
    ovf_s   = 1'b0;
    if (mant_r[13]) begin
      field_s = exp_r[4:0];
    end else begin
      field_s = 5'd0;
    end
    base_s = {field_s, mant_r[12:3]};
`ifdef FP16_PACK_RNE_EN
    inc_s = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
`else
    inc_s = 1'b0;
`endif
    // The carry out of the fraction lands in the exponent field on its own
    sum_s = {1'b0, base_s} + {15'd0, inc_s};
    ovf_s = inf_r | (exp_r >= 6'd31) | (sum_s >= 16'h7C00);
  end

  // Next-state and next-datapath logic for the four-state sequencer
  always_comb begin
    state_n = state_r;
    sign_n  = sign_r;
    exp_n   = exp_r;
    mant_n  = mant_r;
    inf_n   = inf_r;
    q_n     = q_r;
    case (state_r)
      IDLE: begin
        if (IN_VALID) begin
          sign_n  = IN_SIGN_HALF;
          exp_n   = (IN_EXP_HALF == 5'd0) ? 6'd1 : {1'b0, IN_EXP_HALF};
          mant_n  = IN_MANT_SUM;
          inf_n   = 1'b0;
          state_n = NORM;
        end else begin
          state_n = IDLE;
        end
      end
      NORM: begin
        if (exp_r >= 6'd31) begin
          // Infinity in, or a carry pushed the exponent to the top
          inf_n   = 1'b1;
          state_n = ROUND;
        end else if (mant_r == 15'd0) begin
          state_n = ROUND;
        end else if (mant_r[14]) begin
          // Keep the bit shifted out alive in the sticky position
          mant_n = {1'b0, mant_r[14:2], mant_r[1] | mant_r[0]};
          exp_n  = exp_r + 6'd1;
        end else if (!mant_r[13] && (exp_r > 6'd1)) begin
          mant_n = {mant_r[13:0], 1'b0};
          exp_n  = exp_r - 6'd1;
        end else begin
          // Either normalized, or stuck at exponent 1 as a subnormal
          state_n = ROUND;
        end
      end
      ROUND: begin
        if (ovf_s) begin
          q_n = {sign_r, 15'h7C00};
        end else if (mant_r == 15'd0) begin
          q_n = {sign_r, 15'h0000};
        end else begin
          q_n = {sign_r, sum_s[14:0]};
        end
        state_n = DONE;
      end
      DONE: begin
        if (OUT_READY) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      sign_r      <= 1'b0;
      exp_r       <= 6'd0;
      mant_r      <= 15'd0;
      inf_r       <= 1'b0;
      q_r         <= 16'h0000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      sign_r      <= sign_n;
      exp_r       <= exp_n;
      mant_r      <= mant_n;
      inf_r       <= inf_n;
      q_r         <= q_n;
      in_ready_r  <= (state_n == IDLE);
      out_valid_r <= (state_n == DONE);
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign Q         = q_r;

endmodule

// File: tb/tb_fp16_pack_seq.sv
// Self-checking bench for fp16_pack_seq: directed cases, random operands
// against a behavioural reference, backpressure, throughput and mid-flight reset.
module tb_fp16_pack_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign_half;
  logic [4:0]  in_exp_half;
  logic [14:0] in_mant_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;

  int checks;
  int errors;

  fp16_pack_seq dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .IN_VALID     (in_valid),
    .IN_READY     (in_ready),
    .IN_SIGN_HALF (in_sign_half),
    .IN_EXP_HALF  (in_exp_half),
    .IN_MANT_SUM  (in_mant_sum),
    .OUT_VALID    (out_valid),
    .OUT_READY    (out_ready),
    .Q            (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value-level normalization, round and pack from the rules.
  // k = number of shift cycles, so the result appears k+2 edges after accept.
  function automatic void ref_model(input logic s, input logic [4:0] e_in,
                                    input logic [14:0] m_in,
                                    output logic [15:0] qexp, output int k);
    int e, m, msb, sh, field, word, sum;
    bit g, r, st, lsb, inc;
    e = (e_in == 5'd0) ? 1 : int'(e_in);
    m = int'(m_in);
    k = 0;
    qexp = {s, 15'h7C00};
    if (e == 31) begin
      qexp = {s, 15'h7C00};
    end else if (m == 0) begin
      qexp = {s, 15'h0000};
    end else begin
      if (m >= 16384) begin
        m = (m >> 1) | (m & 1);
        e = e + 1;
        k = 1;
      end
      if (e >= 31) begin
        qexp = {s, 15'h7C00};
      end else begin
        msb = 0;
        for (int b = 0; b < 15; b++) if (((m >> b) & 1) == 1) msb = b;
        sh = (msb < 13) ? 13 - msb : 0;
        if (sh > e - 1) sh = e - 1;
        m = m << sh;
        e = e - sh;
        k = k + sh;
        field = (m >= 8192) ? e : 0;
        word = field * 1024 + ((m >> 3) & 1023);
        g   = ((m >> 2) & 1) == 1;
        r   = ((m >> 1) & 1) == 1;
        st  = (m & 1) == 1;
        lsb = ((m >> 3) & 1) == 1;
`ifdef FP16_PACK_RNE_EN
        inc = g && (r || st || lsb);
`else
        inc = 1'b0;
`endif
        sum = word + (inc ? 1 : 0);
        if (sum >= 32'h7C00) qexp = {s, 15'h7C00};
        else qexp = {s, sum[14:0]};
      end
    end
  endfunction

  // Present one operand, accept it at the next edge (edge 0) and wait for OUT_VALID
  task automatic start_and_wait(input logic s, input logic [4:0] e, input logic [14:0] m,
                                output int lat);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_before_op: got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_sign_half = s;
    in_exp_half = e;
    in_mant_sum = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Accept the held result and confirm the block returns to IDLE
  task automatic accept_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_handshake: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  // Run one operand and compare result and latency with the given expectation
  task automatic run_check(input string name, input logic s, input logic [4:0] e,
                           input logic [14:0] m, input logic [15:0] qx, input int latx);
    int lat;
    start_and_wait(s, e, m, lat);
    checks++;
    if (lat !== latx) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, latx);
    end
    checks++;
    if (q !== qx) begin
      errors++;
      $display("FAIL %s_q: got %h want %h", name, q, qx);
    end
    if (lat > 0) accept_result();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_sign_half = 1'b0;
    in_exp_half = 5'd0;
    in_mant_sum = 15'd0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b q=%h want 1/0/0000",
               in_ready, out_valid, q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] rnd_q;
`ifdef FP16_PACK_RNE_EN
    rnd_q = 16'h3C02;
`else
    rnd_q = 16'h3C01;
`endif
    run_check("one",       1'b0, 5'd15, 15'h2000, 16'h3C00, 2);
    run_check("carry",     1'b0, 5'd15, 15'h4000, 16'h4000, 3);
    run_check("cancel",    1'b0, 5'd15, 15'h0100, 16'h2800, 7);
    run_check("subnormal", 1'b0, 5'd1,  15'h0800, 16'h0100, 2);
    run_check("exp0",      1'b0, 5'd0,  15'h0800, 16'h0100, 2);
    run_check("rounding",  1'b0, 5'd15, 15'h200C, rnd_q,    2);
    run_check("ovf_pos",   1'b0, 5'd30, 15'h4000, 16'h7C00, 3);
    run_check("ovf_neg",   1'b1, 5'd30, 15'h4000, 16'hFC00, 3);
    run_check("zero",      1'b1, 5'd10, 15'h0000, 16'h8000, 2);
    run_check("inf_in",    1'b0, 5'd31, 15'h1234, 16'h7C00, 2);
  endtask

  task automatic test_random();
    logic        s;
    logic [4:0]  e;
    logic [14:0] m;
    logic [15:0] qx;
    int          k, pos;
    for (int n = 0; n < 60; n++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       e = 5'd0;
        1:       e = 5'd31;
        2:       e = 5'd30;
        default: e = 5'($urandom_range(1, 30));
      endcase
      pos = $urandom_range(0, 14);
      m = 15'($urandom_range(0, 32767) >> (14 - pos));
      ref_model(s, e, m, qx, k);
      run_check("random", s, e, m, qx, k + 2);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] held;
    start_and_wait(1'b1, 5'd12, 15'h0333, lat);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL bp_timeout: got no out_valid want out_valid");
    end
    held = q;
    in_valid = 1'b1;
    in_mant_sum = 15'h2000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || q !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got out_valid=%b q=%h in_ready=%b want 1/%h/0",
                 out_valid, q, in_ready, held);
      end
    end
    in_valid = 1'b0;
    accept_result();
  endtask

  task automatic test_back_to_back();
    int c;
    bit seen;
    @(negedge clk);
    in_sign_half = 1'b0;
    in_exp_half = 5'd15;
    in_mant_sum = 15'h0100;
    in_valid = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1 seen = (out_valid === 1'b1);
    end
    c = 0;
    seen = 1'b0;
    // out_valid drops on the accept edge, then rises again one period later
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        c = i;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (c !== 9) begin
      errors++;
      $display("FAIL b2b_period: got %0d want 9", c);
    end
    checks++;
    if (q !== 16'h2800) begin
      errors++;
      $display("FAIL b2b_q: got %h want 2800", q);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    in_valid = 1'b1;
    in_sign_half = 1'b0;
    in_exp_half = 5'd20;
    in_mant_sum = 15'h0001;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || q !== 16'h0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_reset: got out_valid=%b q=%h in_ready=%b want 0/0000/1",
               out_valid, q, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_discard: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    run_check("after_reset", 1'b0, 5'd15, 15'h2000, 16'h3C00, 2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_pack_seq.md
# fp16_pack_seq

Sequential half-precision encoder: the output-side counterpart of the FP16 decode/align path. Accepts an unnormalized sign / common exponent / 15-bit extended mantissa sum, as produced by the mantissa adder core. Normalizes it one bit per cycle, rounds it and packs it into an IEEE-754 binary16 word. Sits after the mantissa sum stage and replaces the single-cycle normalizer where an iterative, handshaked result stage is needed.

## Interface
- No parameters; all widths are fixed by binary16.
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- IN_VALID  input  1  the operand triple is valid.
- IN_READY  output  1  block can accept an operand; high only in IDLE.
- IN_SIGN_HALF  input  1  result sign.
- IN_EXP_HALF  input  5  biased exponent of the bit-13 position. 0 is treated as 1 (subnormal scale). 31 means infinity input.
- IN_MANT_SUM  input  15  bit 14 = carry, bit 13 = hidden, bits 12:3 = fraction, bit 2 = guard, bit 1 = round, bit 0 = sticky.
- OUT_VALID  output  1  Q holds a result; held until accepted.
- OUT_READY  input  1  downstream accepts Q.
- Q  output  16  packed binary16 result.

## Operation
- The FSM has four states: IDLE, NORM, ROUND and DONE.
- IDLE: IN_READY=1. On IN_VALID the block captures sign, exponent and mantissa into internal registers and moves to NORM.
  - The exponent register is 6 bits wide. An exponent of 0 is loaded as 1.
- NORM performs at most one action per cycle, checked in this priority order:
  - Exponent field = 31 (infinity input): go to ROUND with the inf flag set.
  - Mantissa = 0: go to ROUND (zero result).
  - Bit 14 = 1: shift right by 1, with the sticky bit ORed with the bit shifted out. Increment the exponent. This happens at most once.
  - Bit 13 = 0 and exponent > 1: shift left by 1 and decrement the exponent.
  - Otherwise go to ROUND. If bit 13 = 0 here, the exponent is 1 and the result is subnormal.
- ROUND computes the packed result and registers it into Q:
  - Exponent field is 0 if bit 13 = 0, otherwise the exponent.
  - The base word is {field, bits 12:3}.
  - With rounding enabled, the increment is G & (R | S | frac LSB). Adding it to the 15-bit word naturally carries into the exponent, including subnormal-to-normal and fraction-overflow cases.
  - If the exponent is ≥ 31 before rounding, or the sum is ≥ 0x7C00, or the inf flag is set, Q = {sign, 0x7C00}.
  - A zero result gives Q = {sign, 15'h0}.
  - NaN is not produced.
- DONE: OUT_VALID=1 and Q is held stable. When OUT_READY is high, go to IDLE.
  - OUT_VALID falls on that edge.
  - A new operand can be accepted in the following cycle (no overlap).

## Timing
- Reset values: state=IDLE, IN_READY=1, OUT_VALID=0, Q=16'h0000, and all internal registers are 0.
- Reset has an asynchronous effect in any state. An operation in flight is discarded with no output.
- Let the accept edge be edge 0 and let k be the number of shift cycles (0..13). OUT_VALID rises at edge k+2.
  - The NORM exit check takes one cycle, and ROUND takes one cycle.
- If OUT_READY is already high when OUT_VALID rises, the result is accepted at the next edge. Throughput is then one result per k+4 cycles.
- Backpressure: while OUT_READY=0 the block stays in DONE indefinitely and Q does not change. Inputs are ignored while not in IDLE.

## Configuration
- FP16_PACK_RNE_EN defined: round to nearest, ties to even, using G, R and S as above.
- FP16_PACK_RNE_EN undefined: truncation. The increment is always 0; G, R and S are ignored; overflow to infinity is still applied.

## Test plan
- 1.0: exp=15, mant=15'h2000, sign=0. Required: Q=16'h3C00, OUT_VALID at edge 2.
- Carry: exp=15, mant=15'h4000. Required: one right shift, Q=16'h4000, OUT_VALID at edge 3.
- Cancellation: exp=15, mant=15'h0100. Required: 5 left shifts, Q=16'h2800, OUT_VALID at edge 7.
- Subnormal: exp=1, mant=15'h0800. Required: Q=16'h0100, with no shifts.
- Rounding: exp=15, mant=15'h200C.
  - With FP16_PACK_RNE_EN: Q=16'h3C02.
  - Without it: Q=16'h3C01.
- Overflow: exp=30, mant=15'h4000. Required: Q=16'h7C00; with sign=1, Q=16'hFC00.
- Boundary: hold OUT_READY=0 for 10 cycles and check that Q and OUT_VALID are stable. Then assert RST_N=0 in the middle of a NORM sequence and check OUT_VALID=0, Q=0 and IN_READY=1 immediately.
